// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake into a small queue,
// and feeds the IF/ID register. Define FETCH_STATS_EN to add fetchCount/flushCount outputs.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        loadad,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic        instValid,
    output logic [31:0] pcNewtoIF,
    output logic [31:0] instoIF
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] flushCount
`endif
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
    localparam logic [31:0]   BUBBLE  = {6'b111111, 26'b0};

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    req_addr_q, req_addr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [31:0]    q_pc_q   [QDEPTH];
    logic [31:0]    q_pc_d   [QDEPTH];
    logic [31:0]    q_inst_q [QDEPTH];
    logic [31:0]    q_inst_d [QDEPTH];
    logic           push;
    logic           pop;
    logic [31:0]    redirect_pc_w;

    assign redirect_pc_w = redirectPc & ~32'h3;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        q_pc_d     = q_pc_q;
        q_inst_d   = q_inst_q;
        push       = (state_q == REQ) && imemAck && !redirect;
        pop        = (count_q != '0) && !loadad && !redirect;

        // A redirect wins over everything: flush the queue and retarget the PC.
        if (redirect) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = redirect_pc_w;
        end else begin
            if (push) begin
                q_pc_d[tail_q]   = fetch_pc_q + 32'd4;
                q_inst_d[tail_q] = imemData;
                tail_d           = tail_q + 1'b1;
                fetch_pc_d       = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end

        case (state_q)
            IDLE: begin
                if (!redirect && (count_q < DEPTH_C)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_d = imemAck ? IDLE : DROP;
                end else if (imemAck) begin
                    state_d = (count_d < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imemAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The outstanding address must stay put while a dropped request drains.
        req_addr_d = (state_d == DROP) ? req_addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            q_pc_q     <= q_pc_d;
            q_inst_q   <= q_inst_d;
        end
    end

    assign imemReq   = (state_q != IDLE);
    assign imemAddr  = req_addr_q;
    assign instValid = (count_q != '0);
    assign pcNewtoIF = instValid ? q_pc_q[head_q] : 32'h0;
    assign instoIF   = instValid ? q_inst_q[head_q] : BUBBLE;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + {31'b0, push};
        flush_count_d = flush_count_q + {31'b0, redirect};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetchCount = fetch_count_q;
    assign flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit with a configurable-latency instruction memory model.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        loadad;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instValid;
    logic [31:0] pcNewtoIF;
    logic [31:0] instoIF;
`ifdef FETCH_STATS_EN
    logic [31:0] fetchCount;
    logic [31:0] flushCount;
`endif

    logic        memOn;
    logic [3:0]  memWait;
    logic [3:0]  waitCnt;

    int checks;
    int failures;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loadad     (loadad),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .instValid  (instValid),
        .pcNewtoIF  (pcNewtoIF),
        .instoIF    (instoIF)
`ifdef FETCH_STATS_EN
        ,
        .fetchCount (fetchCount),
        .flushCount (flushCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks on the (memWait+1)-th cycle of a request; word at address a is {8'hE0, a[23:0]}.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   waitCnt <= 4'd0;
        else if (imemReq && !imemAck) waitCnt <= waitCnt + 4'd1;
        else                          waitCnt <= 4'd0;
    end
    assign imemAck  = memOn && imemReq && (waitCnt == memWait);
    assign imemData = {8'hE0, imemAddr[23:0]};

    typedef struct {
        logic        ld;
        logic        rd;
        logic [31:0] rdPc;
        logic        on;
        logic [3:0]  wt;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eInst;
    } vec_t;

    localparam int NV = 29;
    localparam logic [31:0] BUB = 32'hFC00_0000;
    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        loadad     = v.ld;
        redirect   = v.rd;
        redirectPc = v.rdPc;
        memOn      = v.on;
        memWait    = v.wt;
    endtask

    task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eAddr,
                            input logic eValid, input logic [31:0] ePc, input logic [31:0] eInst);
        checkOutput({tag, ".imemReq"},   {31'b0, imemReq},   {31'b0, eReq});
        checkOutput({tag, ".imemAddr"},  imemAddr,           eAddr);
        checkOutput({tag, ".instValid"}, {31'b0, instValid}, {31'b0, eValid});
        checkOutput({tag, ".pcNewtoIF"}, pcNewtoIF,          ePc);
        checkOutput({tag, ".instoIF"},   instoIF,            eInst);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          ld    rd    rdPc          on    wt    req   addr          vld   pc            inst
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0,        BUB};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b1, 32'h0,        1'b0, 32'h0,        BUB};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b1, 32'h4,        1'b1, 32'h4,        32'hE000_0000};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b1, 32'h8,        1'b1, 32'h8,        32'hE000_0004};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 4'd0, 1'b1, 32'hC,        1'b1, 32'hC,        32'hE000_0008};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h10,       1'b1, 32'hC,        32'hE000_0008};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h10,       1'b1, 32'hC,        32'hE000_0008};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h10,       1'b1, 32'hC,        32'hE000_0008};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h10,       1'b1, 32'hC,        32'hE000_0008};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h10,       1'b1, 32'hC,        32'hE000_0008};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h10,       1'b1, 32'h10,       32'hE000_000C};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b1, 32'h10,       1'b0, 32'h0,        BUB};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 1'b1, 32'h14,       1'b1, 32'h14,       32'hE000_0010};
        vecs[13] = '{1'b0, 1'b1, 32'h100,      1'b1, 4'd2, 1'b1, 32'h14,       1'b0, 32'h0,        BUB};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 1'b1, 32'h14,       1'b0, 32'h0,        BUB};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 1'b0, 32'h100,      1'b0, 32'h0,        BUB};
        vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 1'b1, 32'h100,      1'b0, 32'h0,        BUB};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 1'b1, 32'h100,      1'b0, 32'h0,        BUB};
        vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 1'b1, 32'h100,      1'b0, 32'h0,        BUB};
        vecs[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b1, 32'h104,      1'b1, 32'h104,      32'hE000_0100};
        vecs[20] = '{1'b0, 1'b1, 32'h203,      1'b1, 4'd0, 1'b1, 32'h108,      1'b1, 32'h108,      32'hE000_0104};
        vecs[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h200,      1'b0, 32'h0,        BUB};
        vecs[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b1, 32'h200,      1'b0, 32'h0,        BUB};
        vecs[23] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 4'd0, 1'b1, 32'h204,     1'b1, 32'h204,      32'hE000_0200};
        vecs[24] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0,       BUB};
        vecs[25] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       BUB};
        vecs[26] = '{1'b0, 1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 32'h0,        1'b1, 32'h0,        32'hE0FF_FFFC};
        vecs[27] = '{1'b0, 1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 32'h0,        1'b0, 32'h0,        BUB};
        vecs[28] = '{1'b0, 1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 32'h0,        1'b0, 32'h0,        BUB};

        rst_n = 1'b0;
        applyStimulus(vecs[0]);
        repeat (3) @(negedge clk);
        checkAll("reset", 1'b0, 32'h0, 1'b0, 32'h0, BUB);
`ifdef FETCH_STATS_EN
        checkOutput("reset.fetchCount", fetchCount, 32'd0);
        checkOutput("reset.flushCount", flushCount, 32'd0);
`endif

        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            checkAll($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr,
                     vecs[i].eValid, vecs[i].ePc, vecs[i].eInst);
`ifdef FETCH_STATS_EN
            if (i == 23) checkOutput("flushCount.before", flushCount, 32'd2);
            if (i == 24) checkOutput("flushCount.after",  flushCount, 32'd3);
`endif
            @(posedge clk);
            @(negedge clk);
        end
`ifdef FETCH_STATS_EN
        checkOutput("stats.fetchCount", fetchCount, 32'd9);
        checkOutput("stats.flushCount", flushCount, 32'd3);
`endif

        // Asynchronous reset while a request is outstanding, then a clean restart.
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("asyncReset", 1'b0, 32'h0, 1'b0, 32'h0, BUB);
        memOn   = 1'b1;
        memWait = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        checkAll("restart.c0", 1'b0, 32'h0, 1'b0, 32'h0, BUB);
        @(posedge clk);
        @(negedge clk);
        checkAll("restart.c1", 1'b1, 32'h0, 1'b0, 32'h0, BUB);
        @(posedge clk);
        @(negedge clk);
        checkAll("restart.c2", 1'b1, 32'h4, 1'b1, 32'h4, 32'hE000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
